// File: rtl/ace_sram_arbiter_if.sv
// Bus bundle between the Ace memory masters and the external SRAM controller:
// per-port request/ack handshake plus the async SRAM pins.
interface ace_sram_arbiter_if #(
  parameter int NPORTS = 2,
  parameter int AW     = 21,
  parameter int DW     = 8
);
  logic [NPORTS-1:0]    req;
  logic [NPORTS-1:0]    we;
  logic [NPORTS*AW-1:0] addr;
  logic [NPORTS*DW-1:0] wdata;
  logic [NPORTS-1:0]    ack;
  logic [DW-1:0]        rdata;
  logic                 busy;
  logic [AW-1:0]        sram_addr;
  logic [DW-1:0]        data_to_sram;
  logic [DW-1:0]        data_from_sram;
  logic                 sram_we_n;
  logic                 sram_oe_n;

  modport slave (
    input  req, we, addr, wdata, data_from_sram,
    output ack, rdata, busy, sram_addr, data_to_sram, sram_we_n, sram_oe_n
  );

  modport master (
    output req, we, addr, wdata, data_from_sram,
    input  ack, rdata, busy, sram_addr, data_to_sram, sram_we_n, sram_oe_n
  );
endinterface

// File: rtl/ace_sram_arbiter.sv
// External SRAM controller for the Ace platform: arbitrates NPORTS masters onto one
// async SRAM with a SETUP / STROBE / HOLD access cycle and a one-cycle ack pulse.
module ace_sram_arbiter #(
  parameter int NPORTS      = 2,
  parameter int AW          = 21,
  parameter int DW          = 8,
  parameter int WAIT_CYCLES = 2,
  parameter int ROUND_ROBIN = 0
) (
  input logic               clk,
  input logic               reset_n,
  ace_sram_arbiter_if.slave bus
);

  localparam int IW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam int CW = $clog2(WAIT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_e;

  state_e            state_q, state_d;
  logic [IW-1:0]     grant_q, grant_d;
  logic [IW-1:0]     rr_q, rr_d;
  logic              we_q, we_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [AW-1:0]     sram_addr_q, sram_addr_d;
  logic [DW-1:0]     data_to_sram_q, data_to_sram_d;
  logic [DW-1:0]     rdata_q, rdata_d;
  logic              sram_we_n_q, sram_we_n_d;
  logic              sram_oe_n_q, sram_oe_n_d;
  logic [NPORTS-1:0] ack_q, ack_d;

  logic          found;
  logic [IW-1:0] pick;
  int            idx;

  // Port search: fixed priority starts at 0, round robin starts just past the last winner.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int i = 0; i < NPORTS; i++) begin
      if (ROUND_ROBIN != 0) idx = (int'(rr_q) + 1 + i) % NPORTS;
      else                  idx = i;
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        pick  = IW'(idx);
      end
    end
  end

  // NOTE: every signal gets its default before the case, so no path can infer a latch.
  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    rr_d           = rr_q;
    we_d           = we_q;
    cnt_d          = cnt_q;
    sram_addr_d    = sram_addr_q;
    data_to_sram_d = data_to_sram_q;
    rdata_d        = rdata_q;
    sram_we_n_d    = 1'b1;
    sram_oe_n_d    = 1'b1;
    ack_d          = '0;

    case (state_q)
      IDLE: begin
        if (found) begin
          state_d        = SETUP;
          grant_d        = pick;
          we_d           = bus.we[pick];
          sram_addr_d    = bus.addr[int'(pick)*AW +: AW];
          data_to_sram_d = bus.wdata[int'(pick)*DW +: DW];
          if (ROUND_ROBIN != 0) rr_d = pick;
        end
      end
      SETUP: begin
        state_d     = STROBE;
        cnt_d       = CW'(WAIT_CYCLES - 1);
        sram_we_n_d = !we_q;
        sram_oe_n_d = we_q;
      end
      STROBE: begin
        if (cnt_q == '0) begin
          state_d        = HOLD;
          ack_d[grant_q] = 1'b1;
          if (!we_q) rdata_d = bus.data_from_sram;
        end else begin
          cnt_d       = cnt_q - 1'b1;
          sram_we_n_d = !we_q;
          sram_oe_n_d = we_q;
        end
      end
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      grant_q        <= '0;
      rr_q           <= IW'(NPORTS - 1);
      we_q           <= 1'b0;
      cnt_q          <= '0;
      sram_addr_q    <= '0;
      data_to_sram_q <= '0;
      rdata_q        <= '0;
      sram_we_n_q    <= 1'b1;
      sram_oe_n_q    <= 1'b1;
      ack_q          <= '0;
    end else begin
      state_q        <= state_d;
      grant_q        <= grant_d;
      rr_q           <= rr_d;
      we_q           <= we_d;
      cnt_q          <= cnt_d;
      sram_addr_q    <= sram_addr_d;
      data_to_sram_q <= data_to_sram_d;
      rdata_q        <= rdata_d;
      sram_we_n_q    <= sram_we_n_d;
      sram_oe_n_q    <= sram_oe_n_d;
      ack_q          <= ack_d;
    end
  end

  assign bus.ack          = ack_q;
  assign bus.rdata        = rdata_q;
  assign bus.busy         = (state_q != IDLE);
  assign bus.sram_addr    = sram_addr_q;
  assign bus.data_to_sram = data_to_sram_q;
  assign bus.sram_we_n    = sram_we_n_q;
  assign bus.sram_oe_n    = sram_oe_n_q;

endmodule

// File: tb/tb_ace_sram_arbiter.sv
// Directed bench: a 2-port fixed-priority controller (WAIT_CYCLES=2) and a 4-port
// round-robin controller (WAIT_CYCLES=1), each with a small SRAM model.
module tb_ace_sram_arbiter;

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ace_sram_arbiter_if #(.NPORTS(2), .AW(21), .DW(8)) if_a ();
  ace_sram_arbiter_if #(.NPORTS(4), .AW(21), .DW(8)) if_b ();

  ace_sram_arbiter #(.NPORTS(2), .AW(21), .DW(8), .WAIT_CYCLES(2), .ROUND_ROBIN(0))
    dut_a (.clk(clk), .reset_n(reset_n), .bus(if_a));
  ace_sram_arbiter #(.NPORTS(4), .AW(21), .DW(8), .WAIT_CYCLES(1), .ROUND_ROBIN(1))
    dut_b (.clk(clk), .reset_n(reset_n), .bus(if_b));

  // SRAM models indexed by the low address byte; writes land while we_n is low at an edge.
  logic [7:0] mem_a [256];
  logic [7:0] mem_b [256];

  assign if_a.data_from_sram = mem_a[if_a.sram_addr[7:0]];
  assign if_b.data_from_sram = mem_b[if_b.sram_addr[7:0]];

  always @(posedge clk) begin
    if (!if_a.sram_we_n) mem_a[if_a.sram_addr[7:0]] <= if_a.data_to_sram;
    if (!if_b.sram_we_n) mem_b[if_b.sram_addr[7:0]] <= if_b.data_to_sram;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_ack(input int which, input string tag, output logic [3:0] got);
    logic seen;
    seen = 1'b0;
    got  = '0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      got = (which == 0) ? {2'b00, if_a.ack} : if_b.ack;
      if (got != 4'h0) seen = 1'b1;
    end
    if (!seen) check({tag, " ack timeout"}, 32'(got), 32'hF);
  endtask

  logic [3:0] got;
  logic [3:0] rr_exp [8];

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = 8'h00;
      mem_b[i] = 8'h00;
    end
    mem_a[8'h34] = 8'h5A;
    mem_b[8'h34] = 8'hA5;
    rr_exp = '{4'h2, 4'h8, 4'h2, 4'h8, 4'h1, 4'h2, 4'h1, 4'h2};

    reset_n    = 1'b0;
    if_a.req   = '0; if_a.we = '0; if_a.addr = '0; if_a.wdata = '0;
    if_b.req   = '0; if_b.we = '0; if_b.addr = '0; if_b.wdata = '0;
    repeat (2) @(negedge clk);

    check("rst busy",  32'(if_a.busy),         32'h0);
    check("rst we_n",  32'(if_a.sram_we_n),    32'h1);
    check("rst oe_n",  32'(if_a.sram_oe_n),    32'h1);
    check("rst addr",  32'(if_a.sram_addr),    32'h0);
    check("rst wdat",  32'(if_a.data_to_sram), 32'h0);
    check("rst rdata", 32'(if_a.rdata),        32'h0);
    check("rst ack",   32'(if_a.ack),          32'h0);
    reset_n = 1'b1;

    // Read port 0 at 0x01234: SETUP, two STROBE cycles with oe_n low, then HOLD with ack.
    if_a.req = 2'b01; if_a.we = 2'b00; if_a.addr = {21'h0, 21'h01234};
    @(negedge clk);
    check("rd setup busy", 32'(if_a.busy),      32'h1);
    check("rd setup oe_n", 32'(if_a.sram_oe_n), 32'h1);
    check("rd setup addr", 32'(if_a.sram_addr), 32'h01234);
    @(negedge clk);
    check("rd strobe1 oe_n", 32'(if_a.sram_oe_n), 32'h0);
    check("rd strobe1 we_n", 32'(if_a.sram_we_n), 32'h1);
    check("rd strobe1 ack",  32'(if_a.ack),       32'h0);
    @(negedge clk);
    check("rd strobe2 oe_n", 32'(if_a.sram_oe_n), 32'h0);
    @(negedge clk);
    check("rd hold oe_n",  32'(if_a.sram_oe_n), 32'h1);
    check("rd hold ack",   32'(if_a.ack),       32'h1);
    check("rd hold rdata", 32'(if_a.rdata),     32'h5A);
    if_a.req = 2'b00;
    @(negedge clk);
    check("rd after ack",   32'(if_a.ack),   32'h0);
    check("rd after busy",  32'(if_a.busy),  32'h0);
    check("rd rdata held",  32'(if_a.rdata), 32'h5A);

    // Write port 1: 0xC3 to 0x1FFFF, addr/data stable from SETUP through HOLD.
    if_a.req = 2'b10; if_a.we = 2'b10; if_a.addr = {21'h1FFFF, 21'h0}; if_a.wdata = {8'hC3, 8'h00};
    @(negedge clk);
    check("wr setup addr", 32'(if_a.sram_addr),    32'h1FFFF);
    check("wr setup data", 32'(if_a.data_to_sram), 32'hC3);
    check("wr setup we_n", 32'(if_a.sram_we_n),    32'h1);
    @(negedge clk);
    check("wr strobe1 we_n", 32'(if_a.sram_we_n), 32'h0);
    check("wr strobe1 oe_n", 32'(if_a.sram_oe_n), 32'h1);
    @(negedge clk);
    check("wr strobe2 we_n", 32'(if_a.sram_we_n), 32'h0);
    @(negedge clk);
    check("wr hold we_n", 32'(if_a.sram_we_n),    32'h1);
    check("wr hold ack",  32'(if_a.ack),          32'h2);
    check("wr hold addr", 32'(if_a.sram_addr),    32'h1FFFF);
    check("wr hold data", 32'(if_a.data_to_sram), 32'hC3);
    if_a.req = 2'b00;
    @(negedge clk);
    check("wr ack pulse", 32'(if_a.ack),   32'h0);
    check("wr mem",       32'(mem_a[255]), 32'hC3);

    // Fixed priority with both ports requesting: port 0 wins every time.
    if_a.req = 2'b11; if_a.we = 2'b00; if_a.addr = {21'h00010, 21'h01234};
    for (int n = 0; n < 3; n++) begin
      wait_ack(0, "prio", got);
      check("prio port0 wins", 32'(got), 32'h1);
    end
    if_a.req = 2'b10;
    wait_ack(0, "prio p1", got);
    check("prio port1 after drop", 32'(got), 32'h2);
    if_a.req = 2'b00;
    repeat (3) @(negedge clk);

    // Reset during the write strobe: strobe released at once, no ack.
    if_a.req = 2'b01; if_a.we = 2'b01; if_a.addr = {21'h0, 21'h00055}; if_a.wdata = {8'h00, 8'h77};
    @(negedge clk);
    @(negedge clk);
    check("rstmid strobe we_n", 32'(if_a.sram_we_n), 32'h0);
    reset_n = 1'b0;
    #1;
    check("rstmid we_n", 32'(if_a.sram_we_n), 32'h1);
    check("rstmid busy", 32'(if_a.busy),      32'h0);
    check("rstmid ack",  32'(if_a.ack),       32'h0);
    if_a.req = 2'b00;
    @(negedge clk);
    check("rstmid ack later", 32'(if_a.ack), 32'h0);
    reset_n = 1'b1;
    if_a.req = 2'b01; if_a.we = 2'b00; if_a.addr = {21'h0, 21'h01234};
    wait_ack(0, "post rst", got);
    check("post rst ack",   32'(got),        32'h1);
    check("post rst rdata", 32'(if_a.rdata), 32'h5A);
    if_a.req = 2'b00;

    // Round robin on the 4-port controller: 1,3,1,3 then 0,1,0,1.
    if_b.req = 4'b1010; if_b.we = 4'b0000;
    for (int n = 0; n < 8; n++) begin
      if (n == 4) if_b.req = 4'b0011;
      wait_ack(1, "rr", got);
      check($sformatf("rr grant %0d", n), 32'(got), 32'(rr_exp[n]));
    end
    if_b.req = 4'b0000;
    repeat (3) @(negedge clk);

    // WAIT_CYCLES=1 with req dropped in SETUP: one-cycle strobe, ack still issued.
    if_b.req = 4'b0001; if_b.addr = {63'h0, 21'h01234};
    @(negedge clk);
    check("w1 setup oe_n", 32'(if_b.sram_oe_n), 32'h1);
    if_b.req = 4'b0000;
    @(negedge clk);
    check("w1 strobe oe_n", 32'(if_b.sram_oe_n), 32'h0);
    check("w1 strobe ack",  32'(if_b.ack),       32'h0);
    @(negedge clk);
    check("w1 hold oe_n",  32'(if_b.sram_oe_n), 32'h1);
    check("w1 hold ack",   32'(if_b.ack),       32'h1);
    check("w1 hold rdata", 32'(if_b.rdata),     32'hA5);
    @(negedge clk);
    check("w1 ack pulse", 32'(if_b.ack),  32'h0);
    @(negedge clk);
    check("w1 idle busy", 32'(if_b.busy), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
